// File: rtl/cache_def.sv
// Shared line geometry, data types and bridge state encoding
// for the L1 memory-side line bridge.
package cache_def;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int CNT_W      = IDX_W + 1;
  localparam int BYTE_SH    = $clog2(WORD_W / 8);
  localparam int OFF_W      = $clog2(LINE_W / 8);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_COOL
  } br_state_e;

  function automatic word_t line_word(
    input line_t            l,
    input logic [IDX_W-1:0] i
  );
    word_t w;
    w = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (i == IDX_W'(k)) w = l[k*WORD_W +: WORD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/l1_line_bridge_ctr.sv
// Saturating 32-bit event counter for bridge statistics.
// Sticks at all-ones instead of wrapping.
module l1_line_bridge_ctr (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/l1_line_bridge.sv
// Serializes L1 line refills/write-backs into single-word bus beats.
// Statistics counters exist only with L1_BRIDGE_STATS_EN defined.
module l1_line_bridge
  import cache_def::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_valid_i,
  input  logic              mem_req_rw_i,
  input  logic [ADDR_W-1:0] mem_req_addr_i,
  input  logic [LINE_W-1:0] mem_req_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              bus_valid_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [WORD_W-1:0] bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic              bus_rvalid_i,
  input  logic [WORD_W-1:0] bus_rdata_i,
  output logic [31:0]       no_rd_o,
  output logic [31:0]       no_wr_o,
  output logic [31:0]       no_stall_o
);

  br_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  line_t             wline_q, rline_q;
  logic [CNT_W-1:0]  req_cnt_q, rsp_cnt_q;

  logic              req_take;
  logic              beat_fire;
  logic              rsp_take;
  logic              last_req;
  logic              last_rsp;
  logic [ADDR_W-1:0] beat_addr;

  assign req_take  = (state_q == ST_IDLE) & mem_req_valid_i;
  assign beat_fire = bus_valid_o & bus_ready_i;
  assign rsp_take  = (state_q == ST_READ) & bus_rvalid_i
                   & ~rsp_cnt_q[CNT_W-1];
  assign last_req  = req_cnt_q == CNT_W'(LINE_WORDS - 1);
  assign last_rsp  = rsp_cnt_q == CNT_W'(LINE_WORDS - 1);
  assign beat_addr = base_q + (ADDR_W'(req_cnt_q) << BYTE_SH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_valid_i) begin
          state_d = mem_req_rw_i ? ST_WRITE : ST_READ;
        end
      end
      ST_READ:  if (rsp_take & last_rsp) state_d = ST_DONE;
      ST_WRITE: if (beat_fire & last_req) state_d = ST_DONE;
      ST_DONE:  state_d = ST_COOL;
      ST_COOL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // counter MSB set means every beat of the line has been issued
  always_comb begin
    bus_valid_o = 1'b0;
    bus_we_o    = 1'b0;
    mem_ready_o = 1'b0;
    unique case (1'b1)
      state_q == ST_READ: bus_valid_o = ~req_cnt_q[CNT_W-1];
      state_q == ST_WRITE: begin
        bus_valid_o = 1'b1;
        bus_we_o    = 1'b1;
      end
      state_q == ST_DONE: mem_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign bus_addr_o  = bus_valid_o ? beat_addr : '0;
  assign bus_wdata_o = bus_we_o
                     ? line_word(wline_q, req_cnt_q[IDX_W-1:0])
                     : '0;
  assign mem_data_o  = rline_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q    <= '0;
      wline_q   <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else if (req_take) begin
      base_q    <= {mem_req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      wline_q   <= mem_req_data_i;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (beat_fire) req_cnt_q <= req_cnt_q + CNT_W'(1);
      if (rsp_take)  rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
    end
  end

  // refill words land in place so the line fills word by word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rline_q <= '0;
    end else if (rsp_take) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (rsp_cnt_q[IDX_W-1:0] == IDX_W'(i)) begin
          rline_q[i*WORD_W +: WORD_W] <= bus_rdata_i;
        end
      end
    end
  end

`ifdef L1_BRIDGE_STATS_EN
  l1_line_bridge_ctr u_rd_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (req_take & ~mem_req_rw_i),
    .cnt_o  (no_rd_o)
  );

  l1_line_bridge_ctr u_wr_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (req_take & mem_req_rw_i),
    .cnt_o  (no_wr_o)
  );

  l1_line_bridge_ctr u_stall_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (bus_valid_o & ~bus_ready_i),
    .cnt_o  (no_stall_o)
  );
`else
  assign no_rd_o    = '0;
  assign no_wr_o    = '0;
  assign no_stall_o = '0;
`endif

endmodule

// File: tb/tb_l1_line_bridge.sv
// Directed + randomized bench for l1_line_bridge with a
// transaction-level bus/line model.
module tb_l1_line_bridge;
  import cache_def::*;

  localparam int BUDGET = 400;
  localparam logic [31:0] OFF_MASK = 32'((LINE_W / 8) - 1);

  logic              clk;
  logic              rst_n;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic [LINE_W-1:0] mem_data;
  logic              mem_ready;
  logic              bus_valid;
  logic              bus_we;
  logic [31:0]       bus_addr;
  logic [WORD_W-1:0] bus_wdata;
  logic              bus_ready;
  logic              bus_rvalid;
  logic [WORD_W-1:0] bus_rdata;
  logic [31:0]       no_rd, no_wr, no_stall;

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_stall = 0;
  line_t last_line = '0;

  l1_line_bridge dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mem_req_valid_i (mem_req_valid),
    .mem_req_rw_i    (mem_req_rw),
    .mem_req_addr_i  (mem_req_addr),
    .mem_req_data_i  (mem_req_data),
    .mem_data_o      (mem_data),
    .mem_ready_o     (mem_ready),
    .bus_valid_o     (bus_valid),
    .bus_we_o        (bus_we),
    .bus_addr_o      (bus_addr),
    .bus_wdata_o     (bus_wdata),
    .bus_ready_i     (bus_ready),
    .bus_rvalid_i    (bus_rvalid),
    .bus_rdata_i     (bus_rdata),
    .no_rd_o         (no_rd),
    .no_wr_o         (no_wr),
    .no_stall_o      (no_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_WORDS; i++) l[i*WORD_W +: WORD_W] = $urandom;
    return l;
  endfunction

  task automatic chk_stats();
`ifdef L1_BRIDGE_STATS_EN
    chk("no_rd", no_rd, n_rd);
    chk("no_wr", no_wr, n_wr);
    chk("no_stall", no_stall, n_stall);
`else
    chk("no_rd", no_rd, 0);
    chk("no_wr", no_wr, 0);
    chk("no_stall", no_stall, 0);
`endif
  endtask

  // rmode: 0 ready high, 1 toggling from 1, 2 random
  // smode: 0 reply one cycle after accept, 1 random delay + junk rvalid
  task automatic run_txn(input logic rw, input logic [31:0] addr,
                         input line_t wl, input int rmode,
                         input int smode, input bit hold,
                         output int lat);
    logic [31:0] base;
    logic [31:0] exp_addr;
    word_t       q[$];
    line_t       cur_line;
    int          k, rsp, done_cyc;
    logic        r;
    base     = addr & ~OFF_MASK;
    cur_line = last_line;
    k        = 0;
    rsp      = 0;
    done_cyc = -1;
    lat      = -1;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_data  = wl;
    bus_ready     = 1'b0;
    bus_rvalid    = 1'b0;
    if (rw) n_wr++; else n_rd++;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (!hold) mem_req_valid = 1'b0;
      bus_rvalid = 1'b0;
      chk("mem_ready", mem_ready, cyc == done_cyc);
      chk("mem_data", mem_data, cur_line);
      if (cyc == done_cyc) begin
        lat = cyc;
        if (smode == 1) begin
          bus_rvalid = 1'b1;
          bus_rdata  = $urandom;
        end
        bus_ready = 1'b0;
        break;
      end
      chk("bus_valid", bus_valid, k < LINE_WORDS);
      if (k < LINE_WORDS) begin
        exp_addr = base + 32'(4 * k);
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_we", bus_we, rw);
        if (rw) chk("bus_wdata", bus_wdata, wl[k*WORD_W +: WORD_W]);
      end
      if (q.size() > 0 && (smode == 0 || $urandom_range(0, 1) == 1)) begin
        bus_rvalid = 1'b1;
        bus_rdata  = q.pop_front();
        cur_line[rsp*WORD_W +: WORD_W] = bus_rdata;
        rsp++;
        if (rsp == LINE_WORDS) done_cyc = cyc + 1;
      end else if (smode == 1 && rw && $urandom_range(0, 2) == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = $urandom;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus_ready = r;
      if (k < LINE_WORDS) begin
        if (r) begin
          if (!rw) q.push_back(wl[k*WORD_W +: WORD_W]);
          k++;
          if (rw && k == LINE_WORDS) done_cyc = cyc + 1;
        end else begin
          n_stall++;
        end
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $error("FAIL txn_timeout: got no ready want ready within %0d", BUDGET);
    end
    last_line = cur_line;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("cool_ready", mem_ready, 1'b0);
    chk("cool_valid", bus_valid, 1'b0);
    chk("cool_data", mem_data, last_line);
    if (smode == 1) begin
      bus_rvalid = 1'b1;
      bus_rdata  = $urandom;
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("idle_ready", mem_ready, 1'b0);
    chk("idle_valid", bus_valid, 1'b0);
    chk("idle_data", mem_data, last_line);
  endtask

  initial begin
    int    lat;
    line_t l;
    rst_n         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    bus_ready     = 1'b0;
    bus_rvalid    = 1'b0;
    bus_rdata     = '0;
    #1;
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_data", mem_data, 0);
    chk_stats();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    l = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run_txn(1'b0, 32'h0000_1234, l, 0, 0, 1'b0, lat);
    chk("rd_latency", lat, LINE_WORDS + 2);
    chk("rd_line", mem_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    l = {32'h4, 32'h3, 32'h2, 32'h1};
    run_txn(1'b1, 32'h0000_0040, l, 1, 0, 1'b0, lat);
    chk("wr_latency", lat, 2 * LINE_WORDS);
    chk("wr_keeps_line", mem_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk_stats();

    run_txn(1'b0, 32'h0000_0080, rand_line(), 0, 0, 1'b1, lat);
    chk("b2b_first_lat", lat, LINE_WORDS + 2);
    run_txn(1'b0, 32'h0000_0100, rand_line(), 0, 0, 1'b0, lat);
    chk("b2b_second_lat", lat, LINE_WORDS + 2);

    run_txn(1'b0, 32'hFFFF_FFF0, rand_line(), 0, 0, 1'b0, lat);
    chk("wrap_latency", lat, LINE_WORDS + 2);

    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 32'h0000_2000;
    mem_req_data  = '0;
    @(negedge clk);
    mem_req_valid = 1'b0;
    bus_ready     = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h11;
    @(negedge clk);
    bus_rdata = 32'h22;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("pre_rst_w0", mem_data[31:0], 32'h11);
    chk("pre_rst_w1", mem_data[63:32], 32'h22);
    rst_n     = 1'b0;
    bus_ready = 1'b0;
    #1;
    n_rd = 0;
    n_wr = 0;
    n_stall = 0;
    last_line = '0;
    chk("mid_rst_valid", bus_valid, 1'b0);
    chk("mid_rst_addr", bus_addr, 0);
    chk("mid_rst_ready", mem_ready, 1'b0);
    chk("mid_rst_data", mem_data, 0);
    chk_stats();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h33;
    @(negedge clk);
    bus_rdata = 32'h44;
    @(negedge clk);
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_data", mem_data, 0);
    chk("stale_valid", bus_valid, 1'b0);
    chk("stale_ready", mem_ready, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, rand_line(),
              2, 1, 1'b0, lat);
    end
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
